// File: rtl/tnn_pkg.sv
// tnn_pkg: shared types and helpers for the spike shifter feeders.
//   state_t        - capture FSM states (IDLE, CAPTURE, HOLD)
//   SHIFT_W        - width of the one-hot shift word for a given max magnitude
//   sat_weight     - clamp a signed weight to [-max_mag, +max_mag]
//   sat_encode_bit - one bit of the saturated one-hot shift word
package tnn_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  function automatic int SHIFT_W(input int max_mag);
    return 2 * max_mag + 1;
  endfunction

  function automatic int sat_weight(input int w, input int max_mag);
    if (w > max_mag) return max_mag;
    if (w < -max_mag) return -max_mag;
    return w;
  endfunction

  // Bit index 0 stands for -max_mag, so the set bit sits at w_sat + max_mag.
  // A disabled weight gives the null shift (no bit set).
  function automatic logic sat_encode_bit(input int w, input int max_mag,
                                          input logic en, input int bit_idx);
    return en && ((sat_weight(w, max_mag) + max_mag) == bit_idx);
  endfunction

endpackage

// File: rtl/spike_window_encoder_if.sv
// spike_window_encoder_if: output bundle from the window encoder to the shifter.
//   spike_vec [0:LEN-1]  captured spikes, bit t = spike at time step t
//   shift_mag            one-hot shift word, index 0 = -MAX_SHIFT_MAG
//   out_valid            spike_vec/shift_mag are valid
//   out_ready            shifter consumes the bundle
// Modports: master (encoder side), slave (shifter side).
interface spike_window_encoder_if
  import tnn_pkg::*;
#(
  parameter int LEN           = 8,
  parameter int MAX_SHIFT_MAG = 2
);
  logic [0:LEN-1]                    spike_vec;
  logic [0:SHIFT_W(MAX_SHIFT_MAG)-1] shift_mag;
  logic                              out_valid;
  logic                              out_ready;

  modport master (output spike_vec, output shift_mag, output out_valid, input out_ready);
  modport slave  (input spike_vec, input shift_mag, input out_valid, output out_ready);
endinterface

// File: rtl/mag_onehot_enc.sv
// mag_onehot_enc: combinational signed-weight to one-hot shift word encoder.
//   weight_in  signed two's-complement weight
//   weight_en  0 forces the all-zero (null) shift word
//   shift_mag  saturated one-hot word, index 0 = -MAX_SHIFT_MAG
module mag_onehot_enc
  import tnn_pkg::*;
#(
  parameter int MAX_SHIFT_MAG = 2,
  parameter int WEIGHT_W      = 4
) (
  input  logic signed [WEIGHT_W-1:0]           weight_in,
  input  logic                                 weight_en,
  output logic [0:SHIFT_W(MAX_SHIFT_MAG)-1]    shift_mag
);

  // Each bit compares the clamped weight against its own position, so at most
  // one bit can ever be set.
  for (genvar k = 0; k < SHIFT_W(MAX_SHIFT_MAG); k++) begin : g_bit
    assign shift_mag[k] = sat_encode_bit(int'(weight_in), MAX_SHIFT_MAG, weight_en, k);
  end

endmodule

// File: rtl/spike_window_encoder.sv
// spike_window_encoder: captures a serial spike line over one gamma window of
// LEN steps and pairs it with an encoded shift magnitude for the shifter.
//   clk, rst_n  clock and asynchronous active-low reset
//   start       opens a window (IDLE, or HOLD with a completing handshake)
//   weight_in   signed weight, latched on the accepted start
//   weight_en   latched with start; 0 gives a null shift
//   spike_in    serial spike line, one sample per time step
//   out_if      master side of the output bundle (spike_vec, shift_mag, valid/ready)
//   busy        high while capturing
//   t_step      current time step, 0 outside CAPTURE
module spike_window_encoder
  import tnn_pkg::*;
#(
  parameter int LEN           = 8,
  parameter int MAX_SHIFT_MAG = 2,
  parameter int WEIGHT_W      = 4,
  parameter int FIRST_ONLY    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [WEIGHT_W-1:0]   weight_in,
  input  logic                         weight_en,
  input  logic                         spike_in,
  spike_window_encoder_if.master       out_if,
  output logic                         busy,
  output logic [$clog2(LEN)-1:0]       t_step
);

  localparam int              TW   = $clog2(LEN);
  localparam int              SW   = SHIFT_W(MAX_SHIFT_MAG);
  localparam logic [TW-1:0]   LAST = TW'(LEN - 1);
  localparam bit              KEEP_FIRST = (FIRST_ONLY != 0);

  state_t          state;
  logic [0:LEN-1]  spike_vec_r;
  logic [0:SW-1]   shift_mag_r;
  logic [0:SW-1]   enc_mag;
  logic            out_valid_r;
  logic            accept;
  logic            record;

  mag_onehot_enc #(
    .MAX_SHIFT_MAG (MAX_SHIFT_MAG),
    .WEIGHT_W      (WEIGHT_W)
  ) u_enc (
    .weight_in (weight_in),
    .weight_en (weight_en),
    .shift_mag (enc_mag)
  );

  // A new window may open from IDLE, or straight out of HOLD when the
  // shifter takes the current bundle in the same cycle.
  assign accept = start && ((state == IDLE) || ((state == HOLD) && out_if.out_ready));

  // In first-only mode a spike is dropped once any earlier one was recorded.
  assign record = spike_in && (!KEEP_FIRST || (spike_vec_r == '0));

  // Capture FSM: every output is a register so the bundle stays glitch-free
  // while it is held for the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      spike_vec_r <= '0;
      shift_mag_r <= '0;
      out_valid_r <= 1'b0;
      busy        <= 1'b0;
      t_step      <= '0;
    end else if (accept) begin
      state       <= CAPTURE;
      spike_vec_r <= '0;
      shift_mag_r <= enc_mag;
      out_valid_r <= 1'b0;
      busy        <= 1'b1;
      t_step      <= '0;
    end else begin
      case (state)
        CAPTURE: begin
          if (record) spike_vec_r[t_step] <= 1'b1;
          if (t_step == LAST) begin
            state       <= HOLD;
            out_valid_r <= 1'b1;
            busy        <= 1'b0;
            t_step      <= '0;
          end else begin
            t_step <= t_step + 1'b1;
          end
        end
        HOLD: begin
          if (out_if.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_if.spike_vec = spike_vec_r;
  assign out_if.shift_mag = shift_mag_r;
  assign out_if.out_valid = out_valid_r;

endmodule

// File: tb/tb_spike_window_encoder.sv
// tb_spike_window_encoder: drives a union-mode and a first-only encoder with
// the same inputs and compares both against a window-level reference model.
module tb_spike_window_encoder;

  localparam int LEN = 8;
  localparam int MS  = 2;
  localparam int WW  = 4;
  localparam int TW  = $clog2(LEN);
  localparam int SW  = 2 * MS + 1;
  localparam logic [0:SW-1]  TOPBIT = {1'b1, {(SW-1){1'b0}}};
  localparam logic [0:LEN-1] TOPV   = {1'b1, {(LEN-1){1'b0}}};

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic signed [WW-1:0] weight_in;
  logic                 weight_en;
  logic                 spike_in;
  logic                 out_ready;
  logic                 busy0, busy1;
  logic [TW-1:0]        t_step0, t_step1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic signed [WW-1:0] cur_w;
  logic                 cur_en;
  logic [0:LEN-1]       exp_vec0, exp_vec1;
  logic [0:SW-1]        exp_mag;

  spike_window_encoder_if #(.LEN(LEN), .MAX_SHIFT_MAG(MS)) if0 ();
  spike_window_encoder_if #(.LEN(LEN), .MAX_SHIFT_MAG(MS)) if1 ();

  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;

  spike_window_encoder #(.LEN(LEN), .MAX_SHIFT_MAG(MS), .WEIGHT_W(WW), .FIRST_ONLY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .weight_in(weight_in), .weight_en(weight_en),
    .spike_in(spike_in), .out_if(if0), .busy(busy0), .t_step(t_step0)
  );

  spike_window_encoder #(.LEN(LEN), .MAX_SHIFT_MAG(MS), .WEIGHT_W(WW), .FIRST_ONLY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .weight_in(weight_in), .weight_en(weight_en),
    .spike_in(spike_in), .out_if(if1), .busy(busy1), .t_step(t_step1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: clamp the weight, then place the single bit counted from the
  // -MS end (leftmost position).
  function automatic logic [0:SW-1] magOf(input logic signed [WW-1:0] w, input logic en);
    int wi;
    wi = int'(w);
    if (wi > MS) wi = MS;
    if (wi < -MS) wi = -MS;
    return en ? (TOPBIT >> (wi + MS)) : '0;
  endfunction

  // Reference: earliest spike of the window only.
  function automatic logic [0:LEN-1] firstOf(input logic [0:LEN-1] p);
    for (int t = 0; t < LEN; t++) if (p[TW'(t)]) return TOPV >> t;
    return '0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs are set at a falling edge; the task returns at the next falling
  // edge, where the result of the intervening rising edge is visible.
  task automatic applyStimulus(input logic s, input logic signed [WW-1:0] w, input logic en,
                               input logic sp, input logic rdy);
    start     = s;
    weight_in = w;
    weight_en = en;
    spike_in  = sp;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vec0"},  32'(if0.spike_vec), 32'd0);
    checkOutput({tag, "_vec1"},  32'(if1.spike_vec), 32'd0);
    checkOutput({tag, "_mag"},   32'(if0.shift_mag), 32'd0);
    checkOutput({tag, "_valid"}, 32'(if0.out_valid), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy0), 32'd0);
    checkOutput({tag, "_tstep"}, 32'(t_step0), 32'd0);
  endtask

  task automatic checkHold(input string tag);
    checkOutput({tag, "_valid0"}, 32'(if0.out_valid), 32'd1);
    checkOutput({tag, "_valid1"}, 32'(if1.out_valid), 32'd1);
    checkOutput({tag, "_busy"},   32'(busy0), 32'd0);
    checkOutput({tag, "_tstep"},  32'(t_step0), 32'd0);
    checkOutput({tag, "_vec0"},   32'(if0.spike_vec), 32'(exp_vec0));
    checkOutput({tag, "_vec1"},   32'(if1.spike_vec), 32'(exp_vec1));
    checkOutput({tag, "_mag0"},   32'(if0.shift_mag), 32'(exp_mag));
    checkOutput({tag, "_mag1"},   32'(if1.shift_mag), 32'(exp_mag));
  endtask

  task automatic openWindow(input logic signed [WW-1:0] w, input logic en);
    cur_w  = w;
    cur_en = en;
    applyStimulus(1'b1, w, en, 1'($urandom_range(0, 1)), 1'b1);
    checkOutput("open_busy",  32'(busy0), 32'd1);
    checkOutput("open_tstep", 32'(t_step0), 32'd0);
    checkOutput("open_valid", 32'(if0.out_valid), 32'd0);
  endtask

  task automatic captureWindow(input logic [0:LEN-1] p);
    for (int t = 0; t < LEN; t++) begin
      checkOutput("cap_tstep", 32'(t_step0), 32'(t));
      checkOutput("cap_busy",  32'(busy1), 32'd1);
      checkOutput("cap_valid", 32'(if0.out_valid), 32'd0);
      applyStimulus(1'($urandom_range(0, 1)), WW'($urandom), 1'($urandom_range(0, 1)),
                    p[TW'(t)], 1'($urandom_range(0, 1)));
    end
    exp_vec0 = p;
    exp_vec1 = firstOf(p);
    exp_mag  = magOf(cur_w, cur_en);
    checkHold("done");
  endtask

  task automatic holdCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), WW'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0);
      checkHold("hold");
    end
  endtask

  task automatic releaseOutputs();
    applyStimulus(1'b0, WW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    checkOutput("rel_valid", 32'(if0.out_valid), 32'd0);
    checkOutput("rel_busy",  32'(busy0), 32'd0);
    checkOutput("rel_tstep", 32'(t_step1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    weight_in = '0;
    weight_en = 1'b0;
    spike_in  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;

    // weight +1, single spike at step 3, then a long hold and back-to-back start
    openWindow(4'sd1, 1'b1);
    captureWindow(8'b0001_0000);
    checkOutput("tA_vec",   32'(if0.spike_vec), 32'(8'b0001_0000));
    checkOutput("tA_mag",   32'(if0.shift_mag), 32'(5'b00010));
    holdCycles(20);
    openWindow(-4'sd7, 1'b1);

    // union versus first-only, saturated negative weight
    captureWindow(8'b1100_0110);
    checkOutput("tB_vec0", 32'(if0.spike_vec), 32'(8'b1100_0110));
    checkOutput("tB_vec1", 32'(if1.spike_vec), 32'(8'b1000_0000));
    checkOutput("tB_mag",  32'(if0.shift_mag), 32'(5'b10000));
    releaseOutputs();

    openWindow(4'sd5, 1'b1);
    captureWindow(LEN'($urandom));
    checkOutput("tC_mag", 32'(if0.shift_mag), 32'(5'b00001));
    releaseOutputs();

    openWindow(4'sd1, 1'b0);
    captureWindow(LEN'($urandom));
    checkOutput("tD_mag", 32'(if0.shift_mag), 32'(5'b00000));
    releaseOutputs();

    // reset in the middle of a window
    openWindow(-4'sd1, 1'b1);
    for (int t = 0; t < 4; t++) applyStimulus(1'b0, WW'($urandom), 1'b1, 1'b1, 1'b0);
    checkOutput("mid_tstep", 32'(t_step0), 32'd4);
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // spikes while idle must not leak into the next window
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, WW'($urandom), 1'b1, 1'b1, 1'b0);
    checkOutput("idle_valid", 32'(if0.out_valid), 32'd0);
    openWindow(4'sd2, 1'b1);
    captureWindow(8'b0000_0001);
    checkOutput("clean_vec0", 32'(if0.spike_vec), 32'(8'b0000_0001));
    holdCycles(3);
    releaseOutputs();

    openWindow(4'sd0, 1'b1);
    captureWindow(8'b0000_0000);
    releaseOutputs();

    // randomized windows, mixing idle gaps and back-to-back starts
    for (int i = 0; i < 12; i++) begin
      openWindow(WW'($urandom), 1'($urandom_range(0, 3) != 0));
      captureWindow(LEN'($urandom));
      holdCycles($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) releaseOutputs();
    end
    releaseOutputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_window_encoder.md
Name: spike_window_encoder

Overview:
Upstream feeder for the transmission-gate spike shifter. It captures a serial spike line over one gamma window of LEN time steps into a one-hot/union spike vector. It converts a signed weight into the one-hot shift-magnitude word. It holds both stable under a valid/ready handshake until the shifter stage consumes them.

Parameters:
LEN, 8, time steps per gamma window; width of spike_vec (minimum 2).
MAX_SHIFT_MAG, 2, largest shift magnitude; shift_mag width is 2*MAX_SHIFT_MAG+1.
WEIGHT_W, 4, width of the signed two's-complement weight input (minimum 2).
FIRST_ONLY, 0, 1 records only the earliest spike of the window; 0 records the union of all spikes.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  pulse that opens a capture window; ignored unless the FSM is in IDLE, or in HOLD with a completing handshake.
weight_in  input  WEIGHT_W  signed weight, sampled on the accepted start.
weight_en  input  1  sampled with start; 0 forces an all-zero shift_mag (null shift).
spike_in  input  1  serial spike line, sampled once per time step.
spike_vec  output  [0:LEN-1]  captured spikes; bit t set means a spike at time step t.
shift_mag  output  [0:2*MAX_SHIFT_MAG]  one-hot shift word; bit index 0 is -MAX_SHIFT_MAG and bit index 2*MAX_SHIFT_MAG is +MAX_SHIFT_MAG.
out_valid  output  1  spike_vec and shift_mag are valid.
out_ready  input  1  downstream accepts the outputs.
busy  output  1  high in CAPTURE.
t_step  output  $clog2(LEN)  current time step; 0 outside CAPTURE.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE; spike_vec=0; shift_mag=0; out_valid=0; busy=0; t_step=0.
- FSM states: IDLE, CAPTURE, HOLD.
- IDLE -> CAPTURE on start:
  - spike_vec cleared.
  - Weight latched, saturated to [-MAX_SHIFT_MAG, +MAX_SHIFT_MAG], then encoded.
  - shift_mag = one-hot with bit (w_sat + MAX_SHIFT_MAG) set; all-zero if weight_en=0.
  - t_step = 0.
- CAPTURE, each cycle:
  - If spike_in=1, set spike_vec[t_step] (FIRST_ONLY=1: only if spike_vec is still all-zero).
  - t_step increments by 1.
  - On the cycle where t_step==LEN-1, sample that final step, then go to HOLD with out_valid=1 on the next cycle.
  - Latency: start accepted in cycle 0; out_valid rises in cycle LEN+1.
- HOLD:
  - Outputs are stable while out_valid=1 and out_ready=0.
  - out_ready=1 completes the handshake.
  - Handshake with start=0: go to IDLE, out_valid=0. spike_vec and shift_mag keep their values but are don't-care.
  - Handshake with start=1 in the same cycle: go directly to CAPTURE with new latches (back-to-back windows, no idle bubble).
- Ignored inputs:
  - start in CAPTURE, or in HOLD without out_ready, is ignored. No queuing, no error.
  - spike_in outside CAPTURE is ignored.
- Width and saturation:
  - Weights beyond the range clamp; with MAX_SHIFT_MAG=2, weight_in=-7 gives shift_mag=5'b10000.
  - The encoder never emits more than one set bit.
- t_step never exceeds LEN-1; no wrap inside a window.
- Reset asserted mid-CAPTURE or mid-HOLD aborts immediately to reset values; a partial window is never presented.
- weight_in and weight_en are don't-care except on the accepting cycle.

Decomposition:
- Package tnn_pkg holds:
  - SHIFT_W(MAX_SHIFT_MAG) function
  - the FSM state enum (IDLE, CAPTURE, HOLD)
  - a saturate-and-encode function shared with other shifter feeders
- One combinational sub-module, mag_onehot_enc: signed weight plus enable in, saturated one-hot shift word out.
- The FSM, counter and capture register stay in the top.

Test Plan:
- Defaults; start with weight_in=+1, weight_en=1; spike_in high only at step 3 -> out_valid at cycle 9; spike_vec=8'b0001_0000; shift_mag=5'b00010.
- FIRST_ONLY=0; spikes at steps 0,1,5,6 -> spike_vec=8'b1100_0110. Same stimulus with FIRST_ONLY=1 -> spike_vec=8'b1000_0000.
- weight_in=-7 -> shift_mag=5'b10000; weight_in=+5 -> 5'b00001; weight_en=0 with weight_in=+1 -> 5'b00000.
- out_ready held low 20 cycles -> outputs stable, out_valid=1. A start pulse during the hold is ignored (busy stays 0). Raise out_ready with start=1 -> busy=1 the next cycle, t_step=0.
- Assert rst_n=0 at step 4 of CAPTURE -> all outputs 0 immediately. A new window after release starts clean, with no stale spike bits.
- Spike_in high while IDLE and while in HOLD -> no effect on the next captured spike_vec.
